// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester circular-memory arbiter.
package mem_arb_pkg;

    localparam int DEPTH_LOG2_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for mem_arbiter.
// MEM_ARB_RR_EN: round-robin on contention; otherwise requester 0 has priority.
module mem_arb_pick (
    input  logic [1:0] req,
`ifdef MEM_ARB_RR_EN
    input  logic       last_winner,
`endif
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
`ifdef MEM_ARB_RR_EN
        unique case (req)
            2'b11:   winner = ~last_winner;
            2'b10:   winner = 1'b1;
            default: winner = 1'b0;
        endcase
`else
        winner = req[1] & ~req[0];
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter owning the pointers and strobes of an 8-entry ring.
// MEM_ARB_RR_EN selects round-robin instead of fixed-priority arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            rw,
    output logic [1:0]            grant,
    output logic [1:0]            done,
    output logic [1:0]            err,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic                  full,
    output logic                  empty,
    output logic                  busy
);

    localparam int PW = DEPTH_LOG2 + 1;

    state_t        state_q;
    state_t        state_d;
    op_t           op_q;
    logic          win_q;
    logic          win_d;
    logic          err_q;
    logic          reject;
    logic [1:0]    owner;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

`ifdef MEM_ARB_RR_EN
    logic last_q;
`endif

    mem_arb_pick u_pick (
        .req         (req),
`ifdef MEM_ARB_RR_EN
        .last_winner (last_q),
`endif
        .winner      (win_d)
    );

    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign reject = (op_q == OP_WRITE) ? full : empty;
    assign owner  = win_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req != 2'b00) state_d = CHECK;
            CHECK:   state_d = reject ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            win_q   <= 1'b0;
            err_q   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
`ifdef MEM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req != 2'b00) begin
                win_q <= win_d;
                op_q  <= op_t'(rw[win_d]);
`ifdef MEM_ARB_RR_EN
                last_q <= win_d;
`endif
            end
            if (state_q == CHECK) err_q <= reject;
            if (state_q == ACCESS) begin
                if (op_q == OP_WRITE) wr_ptr <= wr_ptr + 1'b1;
                else                  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // All outputs decode the registered state, so reset clears them at once.
    assign busy     = (state_q != IDLE);
    assign grant    = busy ? owner : 2'b00;
    assign mem_we   = (state_q == ACCESS) && (op_q == OP_WRITE);
    assign mem_re   = (state_q == ACCESS) && (op_q == OP_READ);
    assign done     = (state_q == RESP && !err_q) ? owner : 2'b00;
    assign err      = (state_q == RESP && err_q) ? owner : 2'b00;
    assign mem_addr = (op_q == OP_WRITE) ? wr_ptr[PW-2:0] : rd_ptr[PW-2:0];

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transactions push expectations,
// responses pop and compare them against a small occupancy/pointer model.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] rw  = 2'b00;
    logic [1:0] grant;
    logic [1:0] done;
    logic [1:0] err;
    logic [2:0] mem_addr;
    logic       mem_we;
    logic       mem_re;
    logic       full;
    logic       empty;
    logic       busy;

    always #5 clk = ~clk;

    mem_arbiter #(.DEPTH_LOG2(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .rw       (rw),
        .grant    (grant),
        .done     (done),
        .err      (err),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .full     (full),
        .empty    (empty),
        .busy     (busy)
    );

    typedef struct {
        logic [1:0] gnt;
        bit         is_err;
        bit         is_wr;
        logic [2:0] addr;
    } exp_t;

    exp_t sb[$];
    int pass_cnt = 0;
    int total    = 0;
    int occ      = 0;
    logic [2:0] wp = 3'd0;
    logic [2:0] rp = 3'd0;
    bit lw = 1'b1;

    task automatic run_txn(input logic [1:0] rq, input logic [1:0] rwv,
                           input bit hold);
        exp_t e;
        exp_t got;
        bit w;
        bit seen = 0;
        bit swr = 0;
        int scnt = 0;
        int rk = 0;
        logic [2:0] saddr = 3'd0;
        logic [1:0] rvec = 2'b00;
        bit rerr = 0;
        if (rq == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            w = ~lw;
`else
            w = 1'b0;
`endif
        end else begin
            w = rq[1] & ~rq[0];
        end
        e.gnt    = w ? 2'b10 : 2'b01;
        e.is_wr  = rwv[w];
        e.is_err = e.is_wr ? (occ == 8) : (occ == 0);
        e.addr   = e.is_wr ? wp : rp;
        sb.push_back(e);
        req = rq;
        rw  = rwv;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                total++;
                if (grant !== e.gnt || busy !== 1'b1)
                    $display("FAIL grant_t1: grant=%b busy=%b want %b/1",
                             grant, busy, e.gnt);
                else pass_cnt++;
            end
            if (mem_we || mem_re) begin
                scnt++;
                swr   = mem_we;
                saddr = mem_addr;
            end
            if (done != 2'b00 || err != 2'b00) begin
                seen = 1;
                rk   = k;
                rvec = done | err;
                rerr = (err != 2'b00);
            end
        end
        if (!hold) req = 2'b00;
        total++;
        if (!seen) begin
            $display("FAIL resp_timeout: no done/err within 8 cycles");
            void'(sb.pop_front());
            return;
        end
        pass_cnt++;
        got = sb.pop_front();
        total++;
        if (rvec !== got.gnt)
            $display("FAIL resp_owner: got %b want %b", rvec, got.gnt);
        else pass_cnt++;
        total++;
        if (rerr !== got.is_err)
            $display("FAIL resp_kind: err=%0d want %0d", rerr, got.is_err);
        else pass_cnt++;
        total++;
        if (rk != (got.is_err ? 2 : 3))
            $display("FAIL resp_cycle: got T+%0d want T+%0d",
                     rk, got.is_err ? 2 : 3);
        else pass_cnt++;
        total++;
        if (scnt != (got.is_err ? 0 : 1))
            $display("FAIL strobe_cnt: got %0d want %0d",
                     scnt, got.is_err ? 0 : 1);
        else pass_cnt++;
        if (!got.is_err && scnt == 1) begin
            total++;
            if (swr !== got.is_wr || saddr !== got.addr)
                $display("FAIL strobe: we=%0d addr=%0d want we=%0d addr=%0d",
                         swr, saddr, got.is_wr, got.addr);
            else pass_cnt++;
        end
        lw = w;
        if (!got.is_err) begin
            if (got.is_wr) begin occ++; wp++; end
            else begin occ--; rp++; end
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0)
            $display("FAIL idle_after: busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({grant, done, err} !== 6'b0)
            $display("FAIL rst_hs: grant/done/err=%b want 0",
                     {grant, done, err});
        else pass_cnt++;
        total++;
        if ({mem_we, mem_re, busy} !== 3'b0 || mem_addr !== 3'd0)
            $display("FAIL rst_mem: we/re/busy=%b addr=%0d want 0",
                     {mem_we, mem_re, busy}, mem_addr);
        else pass_cnt++;
        total++;
        if (empty !== 1'b1 || full !== 1'b0)
            $display("FAIL rst_flags: empty=%b full=%b want 1/0", empty, full);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_empty();
        run_txn(2'b10, 2'b00, 0);
        total++;
        if (empty !== 1'b1)
            $display("FAIL rd_empty_flag: empty=%b want 1", empty);
        else pass_cnt++;
    endtask

    task automatic test_first_write();
        run_txn(2'b01, 2'b01, 0);
        total++;
        if (empty !== 1'b0)
            $display("FAIL wr_empty_flag: empty=%b want 0", empty);
        else pass_cnt++;
        run_txn(2'b01, 2'b00, 0);
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) run_txn(2'b01, 2'b01, 0);
        total++;
        if (full !== 1'b1)
            $display("FAIL full_set: full=%b want 1", full);
        else pass_cnt++;
        run_txn(2'b01, 2'b01, 0);
        run_txn(2'b01, 2'b00, 0);
        total++;
        if (full !== 1'b0)
            $display("FAIL full_clr: full=%b want 0", full);
        else pass_cnt++;
        for (int i = 0; i < 7; i++) run_txn(2'b01, 2'b00, 0);
        total++;
        if (empty !== 1'b1)
            $display("FAIL drain_empty: empty=%b want 1", empty);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            run_txn(2'b01, 2'b01, 0);
            total++;
            if (full !== 1'b0)
                $display("FAIL wrap_full[%0d]: full=%b want 0", i, full);
            else pass_cnt++;
            run_txn(2'b01, 2'b00, 0);
            total++;
            if (empty !== 1'b1)
                $display("FAIL wrap_empty[%0d]: empty=%b want 1", i, empty);
            else pass_cnt++;
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++) run_txn(2'b11, 2'b11, i != 3);
        for (int i = 0; i < 4; i++) run_txn(2'b10, 2'b00, 0);
    endtask

    task automatic test_reset_mid();
        bit stray = 0;
        run_txn(2'b01, 2'b01, 0);
        req = 2'b01;
        rw  = 2'b01;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if (mem_we !== 1'b1)
            $display("FAIL mid_access: mem_we=%b want 1", mem_we);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || grant !== 2'b00)
            $display("FAIL mid_drop: we=%b busy=%b grant=%b want 0/0/00",
                     mem_we, busy, grant);
        else pass_cnt++;
        req = 2'b00;
        repeat (3) begin
            @(negedge clk);
            if (done != 2'b00 || err != 2'b00) stray = 1;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done != 2'b00 || err != 2'b00) stray = 1;
        end
        total++;
        if (stray)
            $display("FAIL mid_noresp: done/err seen=1 want 0");
        else pass_cnt++;
        total++;
        if (empty !== 1'b1 || full !== 1'b0 || mem_addr !== 3'd0)
            $display("FAIL mid_ptrs: empty=%b full=%b addr=%0d want 1/0/0",
                     empty, full, mem_addr);
        else pass_cnt++;
        occ = 0;
        wp  = 3'd0;
        rp  = 3'd0;
        lw  = 1'b1;
        run_txn(2'b11, 2'b11, 0);
        run_txn(2'b01, 2'b00, 0);
    endtask

    initial begin
        test_reset();
        test_read_empty();
        test_first_write();
        test_full();
        test_wrap();
        test_contention();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates two requesters for shared access to the 8-entry circular memory and sequences each granted access as check → strobe → response. Owns the read/write pointers and full/empty flags, and drives the single-port memory's address and read/write strobes. Sits between the front-panel/requester logic and the memory array, so each requester sees a simple req/done/err handshake.

## Interface
- DEPTH_LOG2, 3, log2 of memory depth; pointers are DEPTH_LOG2+1 bits (extra wrap bit)
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- req  input  2  per-requester access request; bit i = requester i
- rw  input  2  per-requester operation; 0 = read, 1 = write; sampled with req
- grant  output  2  one-hot owner of the current transaction; 0 when idle
- done  output  2  one-cycle pulse to owner on successful access
- err  output  2  one-cycle pulse to owner on rejected access (write when full, read when empty)
- mem_addr  output  DEPTH_LOG2  memory address: write-pointer low bits for a write op, read-pointer low bits for a read op
- mem_we  output  1  memory write strobe, one cycle
- mem_re  output  1  memory read strobe, one cycle
- full  output  1  wrap bits differ and low bits equal
- empty  output  1  pointers fully equal
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, CHECK, ACCESS, RESP.
- IDLE: if req != 0, select winner, latch winner index and rw[winner], go to CHECK. Otherwise stay in IDLE.
- CHECK: if the latched op is a write and full, or a read and empty, go to RESP with err pending. Otherwise go to ACCESS.
- ACCESS: assert mem_we (write) or mem_re (read) for exactly one cycle. At the end of the cycle, increment write_ptr or read_ptr by 1 modulo 2^(DEPTH_LOG2+1). Then go to RESP.
- RESP: pulse done[winner] or err[winner], then go to IDLE.
- grant[winner] is high in CHECK, ACCESS and RESP.
- full and empty are combinational from the registered pointers.
- A requester holds req until it sees done or err. Dropping req mid-transaction does not abort; the transaction completes.
- rw changes after IDLE sampling are ignored.
- A requester whose req stays high after done is re-arbitrated in the next IDLE cycle.
- Pointer wrap: the low bits wrap 7→0 and the wrap bit toggles. Full and empty stay correct across any number of wraps.
- Exactly 8 writes with no reads → full. A 9th write → err, with pointers unchanged.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight strobe is dropped and no done/err is issued.
- Reset values: state IDLE, both pointers 0, grant 0, done 0, err 0, mem_we 0, mem_re 0, mem_addr 0, busy 0, empty 1, full 0.

## Timing
- Request sampled at edge T (in IDLE).
- grant and busy high from T+1 (CHECK).
- Strobe during cycle T+2 (ACCESS). The pointer has updated by T+3.
- done or err during cycle T+3 (RESP). IDLE at T+4.
- Successful transaction: 4 cycles req-to-IDLE. Rejected transaction: 3 cycles; no strobe; err during T+2.
- Minimum one IDLE cycle between transactions. Back-to-back grants are therefore spaced 4 cycles apart (3 when rejected).
- mem_addr is valid and stable throughout ACCESS.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration with a last_winner register, reset to 1 so requester 0 wins the first contention.
  - On simultaneous requests, the winner is the requester that did not win last.
  - A single requester always wins.
- MEM_ARB_RR_EN undefined:
  - Fixed priority; requester 0 always beats requester 1.
  - No last_winner register.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, CHECK, ACCESS, RESP)
  - the op enum (OP_READ = 0, OP_WRITE = 1)
  - the DEPTH_LOG2 default constant
- Sub-module mem_arb_pick: combinational winner select from req and last_winner. Its RR and fixed-priority bodies are selected by MEM_ARB_RR_EN.

## Test plan
- Reset, then req = 01, rw = 01 → grant = 01 at T+1; mem_we high at T+2 with mem_addr = 0; done[0] at T+3; empty = 0.
- Read on empty after reset, req = 10, rw = 00 → no strobe; err[1] pulse at T+2; pointers stay 0.
- Eight writes from requester 0 → full = 1. Ninth write → err[0]. One read → mem_re with mem_addr = 0, full = 0.
- Sixteen write/read pairs → mem_addr wraps 7→0 twice; empty = 1 after each read; full never asserts.
- req = 11 held, all writes:
  - with MEM_ARB_RR_EN: grants alternate 01, 10, 01, …
  - without it: grant = 01 every time.
- rst low during ACCESS → mem_we drops immediately; done never pulses; pointers 0 and empty = 1 after release.
